// File: rtl/id_exe_stage_reg_pkg.sv
// Shared widths, condition codes, execute-command encodings and the
// control/data bundles carried through the ID->EXE register.
package id_exe_stage_reg_pkg;

    localparam int EXECUTE_COMMAND_LEN = 4;
    localparam int DATA_WIDTH          = 32;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam logic [EXECUTE_COMMAND_LEN-1:0] MOV_EXE = 4'b0001;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] MVN_EXE = 4'b1001;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] ADD_EXE = 4'b0010;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] ADC_EXE = 4'b0011;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] SUB_EXE = 4'b0100;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] SBC_EXE = 4'b0101;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] AND_EXE = 4'b0110;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] ORR_EXE = 4'b0111;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EOR_EXE = 4'b1000;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef struct packed {
        logic [EXECUTE_COMMAND_LEN-1:0] exe_cmd;
        logic                           mem_read;
        logic                           mem_write;
        logic                           wb_enable;
        logic                           branch_taken;
        logic                           status_write_enable;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] val_rn;
        logic [DATA_WIDTH-1:0] val_rm;
        logic                  imm;
        logic [11:0]           shift_operand;
        logic [23:0]           signed_imm_24;
        logic [3:0]            dest;
        logic [3:0]            src1;
        logic [3:0]            src2;
    } data_t;

    localparam ctrl_t CTRL_BUBBLE = '0;
    localparam data_t DATA_CLEAR  = '0;

endpackage

// File: rtl/id_exe_stage_reg_condition_check.sv
// Combinational ARM condition-field evaluation against {N,Z,C,V}.
module condition_check
    import id_exe_stage_reg_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    flags_t f;
    assign f = flags_t'(flags);

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = f.z;
            COND_NE: pass = ~f.z;
            COND_CS: pass = f.c;
            COND_CC: pass = ~f.c;
            COND_MI: pass = f.n;
            COND_PL: pass = ~f.n;
            COND_VS: pass = f.v;
            COND_VC: pass = ~f.v;
            COND_HI: pass = f.c & ~f.z;
            COND_LS: pass = ~f.c | f.z;
            COND_GE: pass = (f.n == f.v);
            COND_LT: pass = (f.n != f.v);
            COND_GT: pass = ~f.z & (f.n == f.v);
            COND_LE: pass = f.z | (f.n != f.v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register: holds the status register, evaluates the
// condition field with a same-cycle flag bypass and launches instruction or bubble.
module id_exe_stage_reg
    import id_exe_stage_reg_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           freeze,
    input  logic                           flush,
    input  logic                           hazard,
    input  logic [EXECUTE_COMMAND_LEN-1:0] exe_cmd,
    input  logic                           mem_read,
    input  logic                           mem_write,
    input  logic                           wb_enable,
    input  logic                           branch_taken,
    input  logic                           status_write_enable,
    input  logic [3:0]                     cond,
    input  logic [DATA_WIDTH-1:0]          pc,
    input  logic [DATA_WIDTH-1:0]          val_rn,
    input  logic [DATA_WIDTH-1:0]          val_rm,
    input  logic                           imm,
    input  logic [11:0]                    shift_operand,
    input  logic [23:0]                    signed_imm_24,
    input  logic [3:0]                     dest,
    input  logic [3:0]                     src1,
    input  logic [3:0]                     src2,
    input  logic [3:0]                     status_in,
    input  logic                           status_update,
    output logic [EXECUTE_COMMAND_LEN-1:0] exe_cmd_out,
    output logic                           mem_read_out,
    output logic                           mem_write_out,
    output logic                           wb_enable_out,
    output logic                           branch_taken_out,
    output logic                           status_write_enable_out,
    output logic [DATA_WIDTH-1:0]          pc_out,
    output logic [DATA_WIDTH-1:0]          val_rn_out,
    output logic [DATA_WIDTH-1:0]          val_rm_out,
    output logic                           imm_out,
    output logic [11:0]                    shift_operand_out,
    output logic [23:0]                    signed_imm_24_out,
    output logic [3:0]                     dest_out,
    output logic [3:0]                     src1_out,
    output logic [3:0]                     src2_out,
    output logic [3:0]                     status,
    output logic                           cond_pass
);

    ctrl_t      ctrl_in;
    ctrl_t      ctrl_q;
    data_t      data_in;
    data_t      data_q;
    logic [3:0] status_q;
    logic [3:0] flags;

    assign ctrl_in = '{
        exe_cmd:             exe_cmd,
        mem_read:            mem_read,
        mem_write:           mem_write,
        wb_enable:           wb_enable,
        branch_taken:        branch_taken,
        status_write_enable: status_write_enable
    };

    assign data_in = '{
        pc:            pc,
        val_rn:        val_rn,
        val_rm:        val_rm,
        imm:           imm,
        shift_operand: shift_operand,
        signed_imm_24: signed_imm_24,
        dest:          dest,
        src1:          src1,
        src2:          src2
    };

    // The instruction in EXE may be writing flags this very cycle; evaluate against those.
    assign flags = status_update ? status_in : status_q;

    condition_check u_condition_check (
        .cond  (cond),
        .flags (flags),
        .pass  (cond_pass)
    );

    // Flag write belongs to the older EXE instruction, so only freeze may block it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= CTRL_BUBBLE;
            data_q   <= DATA_CLEAR;
            status_q <= 4'b0000;
        end else if (!freeze) begin
            if (status_update) begin
                status_q <= status_in;
            end
            if (flush) begin
                ctrl_q <= CTRL_BUBBLE;
                data_q <= DATA_CLEAR;
            end else begin
                data_q <= data_in;
                ctrl_q <= (hazard || !cond_pass) ? CTRL_BUBBLE : ctrl_in;
            end
        end
    end

    assign exe_cmd_out             = ctrl_q.exe_cmd;
    assign mem_read_out            = ctrl_q.mem_read;
    assign mem_write_out           = ctrl_q.mem_write;
    assign wb_enable_out           = ctrl_q.wb_enable;
    assign branch_taken_out        = ctrl_q.branch_taken;
    assign status_write_enable_out = ctrl_q.status_write_enable;
    assign pc_out                  = data_q.pc;
    assign val_rn_out              = data_q.val_rn;
    assign val_rm_out              = data_q.val_rm;
    assign imm_out                 = data_q.imm;
    assign shift_operand_out       = data_q.shift_operand;
    assign signed_imm_24_out       = data_q.signed_imm_24;
    assign dest_out                = data_q.dest;
    assign src1_out                = data_q.src1;
    assign src2_out                = data_q.src2;
    assign status                  = status_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg: directed scenarios plus a
// randomized run against a behavioural model of the register and flags.
module tb_id_exe_stage_reg;
    import id_exe_stage_reg_pkg::*;

    logic        clk;
    logic        rst, freeze, flush, hazard;
    logic [3:0]  exe_cmd;
    logic        mem_read, mem_write, wb_enable, branch_taken, status_write_enable;
    logic [3:0]  cond;
    logic [31:0] pc, val_rn, val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest, src1, src2;
    logic [3:0]  status_in;
    logic        status_update;

    logic [3:0]  exe_cmd_out;
    logic        mem_read_out, mem_write_out, wb_enable_out, branch_taken_out, status_write_enable_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic        imm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [3:0]  dest_out, src1_out, src2_out;
    logic [3:0]  status;
    logic        cond_pass;

    int tests_run;
    int tests_failed;

    // Expected state kept by the reference model.
    logic [8:0]   m_ctrl;
    logic [144:0] m_data;
    logic [3:0]   m_status;

    logic [8:0]   act_ctrl;
    logic [144:0] act_data;

    assign act_ctrl = {exe_cmd_out, mem_read_out, mem_write_out, wb_enable_out,
                       branch_taken_out, status_write_enable_out};
    assign act_data = {pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
                       signed_imm_24_out, dest_out, src1_out, src2_out};

    id_exe_stage_reg dut (
        .clk                     (clk),
        .rst                     (rst),
        .freeze                  (freeze),
        .flush                   (flush),
        .hazard                  (hazard),
        .exe_cmd                 (exe_cmd),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .wb_enable               (wb_enable),
        .branch_taken            (branch_taken),
        .status_write_enable     (status_write_enable),
        .cond                    (cond),
        .pc                      (pc),
        .val_rn                  (val_rn),
        .val_rm                  (val_rm),
        .imm                     (imm),
        .shift_operand           (shift_operand),
        .signed_imm_24           (signed_imm_24),
        .dest                    (dest),
        .src1                    (src1),
        .src2                    (src2),
        .status_in               (status_in),
        .status_update           (status_update),
        .exe_cmd_out             (exe_cmd_out),
        .mem_read_out            (mem_read_out),
        .mem_write_out           (mem_write_out),
        .wb_enable_out           (wb_enable_out),
        .branch_taken_out        (branch_taken_out),
        .status_write_enable_out (status_write_enable_out),
        .pc_out                  (pc_out),
        .val_rn_out              (val_rn_out),
        .val_rm_out              (val_rm_out),
        .imm_out                 (imm_out),
        .shift_operand_out       (shift_operand_out),
        .signed_imm_24_out       (signed_imm_24_out),
        .dest_out                (dest_out),
        .src1_out                (src1_out),
        .src2_out                (src2_out),
        .status                  (status),
        .cond_pass               (cond_pass)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Condition semantics in terms of signed/unsigned comparison outcomes.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, equal, uns_higher, sgn_ge;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        equal      = z;
        uns_higher = cy && !z;
        sgn_ge     = (n == v);
        case (c)
            4'd0:  return equal;
            4'd1:  return !equal;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return uns_higher;
            4'd9:  return !uns_higher;
            4'd10: return sgn_ge;
            4'd11: return !sgn_ge;
            4'd12: return sgn_ge && !equal;
            4'd13: return !(sgn_ge && !equal);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic model_pass();
        return ref_pass(cond, status_update ? status_in : m_status);
    endfunction

    // Advance the model with the current inputs, then let the DUT see the edge.
    task automatic tick();
        logic p;
        p = model_pass();
        if (rst) begin
            m_ctrl = '0; m_data = '0; m_status = 4'b0000;
        end else if (!freeze) begin
            if (status_update) m_status = status_in;
            if (flush) begin
                m_ctrl = '0; m_data = '0;
            end else begin
                m_data = {pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest, src1, src2};
                m_ctrl = (hazard || !p) ? 9'd0
                       : {exe_cmd, mem_read, mem_write, wb_enable, branch_taken, status_write_enable};
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_payload();
        exe_cmd = 4'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
        wb_enable = 1'($urandom); branch_taken = 1'($urandom); status_write_enable = 1'($urandom);
        cond = 4'($urandom); pc = $urandom; val_rn = $urandom; val_rm = $urandom;
        imm = 1'($urandom); shift_operand = 12'($urandom); signed_imm_24 = 24'($urandom);
        dest = 4'($urandom); src1 = 4'($urandom); src2 = 4'($urandom);
        status_in = 4'($urandom);
    endtask

    task automatic quiet_controls();
        rst = 0; freeze = 0; flush = 0; hazard = 0; status_update = 0;
    endtask

    task automatic set_status(input logic [3:0] f);
        quiet_controls();
        status_update = 1; status_in = f; cond = 4'b1111;
        tick();
        status_update = 0;
    endtask

    task automatic test_reset();
        quiet_controls();
        rst = 1;
        randomize_payload(); status_update = 1; cond = 4'b1110;
        tick();
        randomize_payload();
        tick();
        tests_run++;
        if (act_ctrl !== 9'd0 || act_data !== 145'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outs: got ctrl=%h data=%h, want 0", act_ctrl, act_data);
        end
        tests_run++;
        if (status !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_status: got %b, want 0000", status);
        end
        quiet_controls();
        cond = 4'b1110;
        #1;
        tests_run++;
        if (cond_pass !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_al_pass: got %b, want 1", cond_pass);
        end
        cond = 4'b0000;
        #1;
        tests_run++;
        if (cond_pass !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_eq_fail: got %b, want 0", cond_pass);
        end
        tick();
    endtask

    task automatic test_cond_pass_fail();
        set_status(4'b0100);
        randomize_payload();
        exe_cmd = ADD_EXE; wb_enable = 1; mem_read = 0; mem_write = 0; branch_taken = 0;
        cond = 4'b0000; dest = 4'd7;
        tick();
        tests_run++;
        if (wb_enable_out !== 1'b1 || exe_cmd_out !== ADD_EXE || act_ctrl !== m_ctrl) begin
            tests_failed++;
            $display("[TB] FAIL cond_eq_pass: got ctrl=%h, want %h", act_ctrl, m_ctrl);
        end
        cond = 4'b0001; dest = 4'd9;
        tick();
        tests_run++;
        if (act_ctrl !== 9'd0) begin
            tests_failed++;
            $display("[TB] FAIL cond_ne_bubble: got ctrl=%h, want 0", act_ctrl);
        end
        tests_run++;
        if (dest_out !== 4'd9 || act_data !== m_data) begin
            tests_failed++;
            $display("[TB] FAIL cond_ne_data: got dest=%0d, want 9", dest_out);
        end
    endtask

    task automatic test_flag_bypass();
        set_status(4'b0000);
        randomize_payload();
        status_update = 1; status_in = 4'b0100; cond = 4'b0000;
        #1;
        tests_run++;
        if (cond_pass !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bypass_pass: got %b, want 1", cond_pass);
        end
        tick();
        status_update = 0;
        tests_run++;
        if (status !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL bypass_status: got %b, want 0100", status);
        end
    endtask

    task automatic test_flush_hazard();
        quiet_controls();
        randomize_payload();
        exe_cmd = MOV_EXE; wb_enable = 1; cond = 4'b1110; val_rn = 32'hCAFE_0001;
        flush = 1;
        tick();
        tests_run++;
        if (act_ctrl !== 9'd0 || act_data !== 145'd0) begin
            tests_failed++;
            $display("[TB] FAIL flush: got ctrl=%h data=%h, want 0", act_ctrl, act_data);
        end
        flush = 0; hazard = 1;
        tick();
        tests_run++;
        if (act_ctrl !== 9'd0 || val_rn_out !== 32'hCAFE_0001) begin
            tests_failed++;
            $display("[TB] FAIL hazard: got ctrl=%h val_rn=%h, want 0 cafe0001", act_ctrl, val_rn_out);
        end
        flush = 1; hazard = 1; dest = 4'd5;
        tick();
        tests_run++;
        if (act_ctrl !== 9'd0 || act_data !== 145'd0 || dest_out !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL flush_hazard: got ctrl=%h dest=%0d, want 0 0", act_ctrl, dest_out);
        end
        quiet_controls();
    endtask

    task automatic test_freeze();
        logic [3:0] held_status;
        quiet_controls();
        randomize_payload();
        pc = 32'h0000_0010; cond = 4'b1110; exe_cmd = SUB_EXE; wb_enable = 1;
        tick();
        held_status = m_status;
        for (int i = 0; i < 3; i++) begin
            randomize_payload();
            freeze = 1; status_update = 1; flush = (i == 1);
            tick();
            tests_run++;
            if (pc_out !== 32'h0000_0010 || act_ctrl !== m_ctrl || act_data !== m_data) begin
                tests_failed++;
                $display("[TB] FAIL freeze_hold_%0d: got pc=%h ctrl=%h, want pc=00000010 ctrl=%h",
                         i, pc_out, act_ctrl, m_ctrl);
            end
            tests_run++;
            if (status !== held_status) begin
                tests_failed++;
                $display("[TB] FAIL freeze_status_%0d: got %b, want %b", i, status, held_status);
            end
        end
        quiet_controls();
        randomize_payload();
        pc = 32'h0000_0014; cond = 4'b1110;
        tick();
        tests_run++;
        if (pc_out !== 32'h0000_0014 || act_ctrl !== m_ctrl || act_data !== m_data) begin
            tests_failed++;
            $display("[TB] FAIL freeze_release: got pc=%h, want 00000014", pc_out);
        end
    endtask

    task automatic test_signed_conditions();
        logic [3:0] codes [6];
        logic       want  [6];
        codes[0] = 4'b1010; want[0] = 0;
        codes[1] = 4'b1011; want[1] = 1;
        codes[2] = 4'b1100; want[2] = 0;
        codes[3] = 4'b1101; want[3] = 1;
        codes[4] = 4'b1000; want[4] = 1;
        codes[5] = 4'b1001; want[5] = 0;
        set_status(4'b1000);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) set_status(4'b0010);
            cond = codes[i];
            #1;
            tests_run++;
            if (cond_pass !== want[i]) begin
                tests_failed++;
                $display("[TB] FAIL signed_cond_%b: got %b, want %b", codes[i], cond_pass, want[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            randomize_payload();
            rst           = ($urandom_range(0, 49) == 0);
            freeze        = ($urandom_range(0, 7) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            hazard        = ($urandom_range(0, 5) == 0);
            status_update = ($urandom_range(0, 2) == 0);
            #1;
            if (!rst) begin
                tests_run++;
                if (cond_pass !== model_pass()) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_cond_pass_%0d: got %b, want %b", i, cond_pass, model_pass());
                end
            end
            tick();
            tests_run++;
            if (act_ctrl !== m_ctrl || act_data !== m_data || status !== m_status) begin
                tests_failed++;
                $display("[TB] FAIL rand_step_%0d: got ctrl=%h status=%b, want ctrl=%h status=%b",
                         i, act_ctrl, status, m_ctrl, m_status);
            end
        end
        quiet_controls();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        m_ctrl = '0; m_data = '0; m_status = '0;
        quiet_controls();
        randomize_payload();
        test_reset();
        test_cond_pass_fail();
        test_flag_bypass();
        test_flush_hazard();
        test_freeze();
        test_signed_conditions();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
